// File: rtl/sata_phy_align_ctrl.sv
// sata_phy_align_ctrl: ALIGN scheduler and RX link-integrity monitor.
// After linkup it owns the TX dword stream, interleaving periodic ALIGN bursts
// with link-layer data, and supervises RX ALIGN spacing and phy_error density.
// Build option: define SATA_PHY_RX_ALIGN_FILTER_EN to drop detected RX ALIGN
// dwords from the stream forwarded to the link layer.
module sata_phy_align_ctrl #(
    parameter int unsigned ALIGN_INTERVAL   = 256,
    parameter int unsigned ALIGN_BURST      = 2,
    parameter int unsigned RX_ALIGN_TIMEOUT = 1024,
    parameter int unsigned ERR_WINDOW       = 256,
    parameter int unsigned ERR_THRESHOLD    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        linkup,
    input  logic [31:0] oob_tx_dout,
    input  logic        oob_tx_isk,
    input  logic [31:0] link_tx_dout,
    input  logic        link_tx_isk,
    output logic        link_tx_ready,
    output logic [31:0] tx_dout,
    output logic        tx_isk,
    input  logic [31:0] rx_din,
    input  logic [3:0]  rx_isk,
    input  logic        phy_error,
    output logic [31:0] rx_dout,
    output logic [3:0]  rx_isk_out,
    output logic        rx_valid,
    output logic        phy_ready,
    output logic        platform_error
);

    // ALIGN primitive: K28.5 D10.2 D10.2 D27.3, K flag on byte 0.
    localparam logic [31:0] PRIM_ALIGN = 32'h7B4A_4ABC;

    localparam int unsigned BURST_W = $clog2(ALIGN_BURST) + 1;
    localparam int unsigned INT_W   = $clog2(ALIGN_INTERVAL) + 1;
    localparam int unsigned GAP_W   = $clog2(RX_ALIGN_TIMEOUT + 1) + 1;
    localparam int unsigned WIN_W   = $clog2(ERR_WINDOW) + 1;
    localparam int unsigned ERR_W   = $clog2(ERR_THRESHOLD + 1) + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ALIGN = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [BURST_W-1:0] burst_cnt;
    logic [BURST_W-1:0] burst_cnt_nxt;
    logic [INT_W-1:0]   int_cnt;
    logic [INT_W-1:0]   int_cnt_nxt;

    logic               align_det;
    logic [GAP_W-1:0]   gap_cnt;
    logic [GAP_W-1:0]   gap_inc;
    logic               gap_trip;
    logic [WIN_W-1:0]   win_cnt;
    logic               win_wrap;
    logic [ERR_W-1:0]   err_cnt;
    logic [ERR_W-1:0]   err_base;
    logic [ERR_W-1:0]   err_inc;
    logic               err_trip;

    // State and sequencing counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            burst_cnt <= '0;
            int_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            burst_cnt <= burst_cnt_nxt;
            int_cnt   <= int_cnt_nxt;
        end
    end

    // Next state; counters restart from zero on every state entry.
    always_comb begin
        state_nxt     = state;
        burst_cnt_nxt = '0;
        int_cnt_nxt   = '0;
        if (!linkup) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt = ST_ALIGN;
                end
                ST_ALIGN: begin
                    if (burst_cnt == BURST_W'(ALIGN_BURST - 1)) begin
                        state_nxt = ST_DATA;
                    end else begin
                        burst_cnt_nxt = burst_cnt + BURST_W'(1);
                    end
                end
                ST_DATA: begin
                    if (int_cnt == INT_W'(ALIGN_INTERVAL - 1)) begin
                        state_nxt = ST_ALIGN;
                    end else begin
                        int_cnt_nxt = int_cnt + INT_W'(1);
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Link layer is served only while in DATA.
    assign link_tx_ready = (state == ST_DATA);
    assign phy_ready     = (state == ST_DATA);

    // TX source mux, registered towards the transceiver.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_dout <= '0;
            tx_isk  <= 1'b0;
        end else begin
            case (state)
                ST_ALIGN: begin
                    tx_dout <= PRIM_ALIGN;
                    tx_isk  <= 1'b1;
                end
                ST_DATA: begin
                    tx_dout <= link_tx_dout;
                    tx_isk  <= link_tx_isk;
                end
                default: begin
                    tx_dout <= oob_tx_dout;
                    tx_isk  <= oob_tx_isk;
                end
            endcase
        end
    end

    // An ALIGN received together with a decode error is not trusted.
    assign align_det = (rx_din == PRIM_ALIGN) && rx_isk[0] && !phy_error;

    // RX forwarding path to the link layer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_dout    <= '0;
            rx_isk_out <= '0;
            rx_valid   <= 1'b0;
        end else begin
`ifdef SATA_PHY_RX_ALIGN_FILTER_EN
            rx_valid <= linkup && !align_det;
            if (!align_det) begin
                rx_dout    <= rx_din;
                rx_isk_out <= rx_isk;
            end
`else
            rx_valid   <= linkup;
            rx_dout    <= rx_din;
            rx_isk_out <= rx_isk;
`endif
        end
    end

    // Gap trips when the incremented count reaches the timeout; a zero timeout never trips.
    assign gap_inc  = gap_cnt + GAP_W'(1);
    assign gap_trip = (RX_ALIGN_TIMEOUT != 0) && !align_det
                      && (gap_cnt < GAP_W'(RX_ALIGN_TIMEOUT))
                      && (gap_inc == GAP_W'(RX_ALIGN_TIMEOUT));

    // The error arriving on the wrap cycle is counted into the fresh window.
    assign win_wrap = (win_cnt == WIN_W'(ERR_WINDOW - 1));
    assign err_base = win_wrap ? '0 : err_cnt;
    assign err_inc  = err_base + ERR_W'(1);
    assign err_trip = phy_error && (err_base < ERR_W'(ERR_THRESHOLD))
                      && (err_inc == ERR_W'(ERR_THRESHOLD));

    // RX supervision counters and the sticky integrity fault.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt        <= '0;
            win_cnt        <= '0;
            err_cnt        <= '0;
            platform_error <= 1'b0;
        end else if (!linkup) begin
            gap_cnt        <= '0;
            win_cnt        <= '0;
            err_cnt        <= '0;
            platform_error <= 1'b0;
        end else begin
            if (align_det) begin
                gap_cnt <= '0;
            end else if (gap_cnt < GAP_W'(RX_ALIGN_TIMEOUT)) begin
                gap_cnt <= gap_inc;
            end
            win_cnt <= win_wrap ? '0 : win_cnt + WIN_W'(1);
            if (phy_error && (err_base < ERR_W'(ERR_THRESHOLD))) begin
                err_cnt <= err_inc;
            end else begin
                err_cnt <= err_base;
            end
            platform_error <= platform_error | gap_trip | err_trip;
        end
    end

endmodule

// File: tb/tb_sata_phy_align_ctrl.sv
// Self-checking bench for sata_phy_align_ctrl using scoreboard queues.
module tb_sata_phy_align_ctrl;

    localparam int AI = 8;
    localparam int AB = 3;
    localparam int TO = 16;
    localparam int EW = 32;
    localparam int ET = 4;
    localparam int P  = AI + AB;
    localparam logic [31:0] ALIGN = 32'h7B4A_4ABC;
    localparam logic [31:0] LBASE = 32'h1000_0000;

    typedef struct packed {
        logic [31:0] d;
        logic        k;
        logic        rdy;
    } tx_exp_t;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        v;
    } rx_exp_t;

    logic        clk;
    logic        rst_n;
    logic        linkup;
    logic [31:0] oob_tx_dout;
    logic        oob_tx_isk;
    logic [31:0] link_tx_dout;
    logic        link_tx_isk;
    logic        link_tx_ready;
    logic [31:0] tx_dout;
    logic        tx_isk;
    logic [31:0] rx_din;
    logic [3:0]  rx_isk;
    logic        phy_error;
    logic [31:0] rx_dout;
    logic [3:0]  rx_isk_out;
    logic        rx_valid;
    logic        phy_ready;
    logic        platform_error;

    int n_checks = 0;
    int n_pass   = 0;
    int rx_ph    = 0;
    bit rx_auto  = 0;
    int link_cnt = 0;

    tx_exp_t sb_tx[$];
    rx_exp_t sb_rx[$];

    sata_phy_align_ctrl #(
        .ALIGN_INTERVAL  (AI),
        .ALIGN_BURST     (AB),
        .RX_ALIGN_TIMEOUT(TO),
        .ERR_WINDOW      (EW),
        .ERR_THRESHOLD   (ET)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .linkup        (linkup),
        .oob_tx_dout   (oob_tx_dout),
        .oob_tx_isk    (oob_tx_isk),
        .link_tx_dout  (link_tx_dout),
        .link_tx_isk   (link_tx_isk),
        .link_tx_ready (link_tx_ready),
        .tx_dout       (tx_dout),
        .tx_isk        (tx_isk),
        .rx_din        (rx_din),
        .rx_isk        (rx_isk),
        .phy_error     (phy_error),
        .rx_dout       (rx_dout),
        .rx_isk_out    (rx_isk_out),
        .rx_valid      (rx_valid),
        .phy_ready     (phy_ready),
        .platform_error(platform_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected TX word and ready after the k-th edge since linkup was first sampled high.
    function automatic tx_exp_t model_tx(input int k);
        tx_exp_t e;
        int p;
        int ph;
        p  = k - 1;
        ph = p % P;
        if (ph < AB) begin
            e.d = ALIGN;
            e.k = 1'b1;
        end else begin
            e.d = LBASE + 32'((p / P) * AI + ph - AB);
            e.k = 1'b0;
        end
        e.rdy = ((k % P) >= AB);
        return e;
    endfunction

    // One clock; optional background RX stream with an ALIGN every 4th dword.
    task automatic tick();
        if (rx_auto) begin
            rx_ph++;
            if (rx_ph % 4 == 0) begin
                rx_din = ALIGN;
                rx_isk = 4'b0001;
            end else begin
                rx_din = 32'hC0DE_0000 | 32'(rx_ph);
                rx_isk = 4'b0000;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Link-layer source: presents an incrementing counter, advances when accepted.
    task automatic link_tick();
        logic rdy;
        link_tx_dout = LBASE + 32'(link_cnt);
        link_tx_isk  = 1'b0;
        rdy = link_tx_ready;
        tick();
        if (rdy) link_cnt++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        linkup = 1'b0;
        oob_tx_dout = 32'hDEAD_BEEF;
        oob_tx_isk = 1'b1;
        link_tx_dout = '0;
        link_tx_isk = 1'b0;
        rx_din = 32'h5555_AAAA;
        rx_isk = 4'hF;
        phy_error = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({tx_dout, tx_isk, rx_dout, rx_isk_out, rx_valid} !== 70'd0)
            $display("FAIL reset_data: got %h/%b/%h/%h/%b required all 0", tx_dout, tx_isk, rx_dout, rx_isk_out, rx_valid);
        else n_pass++;
        n_checks++;
        if ({link_tx_ready, phy_ready, platform_error} !== 3'b000)
            $display("FAIL reset_flags: got %b%b%b required 000", link_tx_ready, phy_ready, platform_error);
        else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_bringup();
        tx_exp_t e;
        linkup = 1'b0;
        rx_auto = 1'b1;
        link_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            oob_tx_dout = 32'h0B0B_0000 + 32'(i);
            oob_tx_isk = (i % 3 == 0);
            sb_tx.push_back('{d: oob_tx_dout, k: oob_tx_isk, rdy: 1'b0});
            link_tick();
            e = sb_tx.pop_front();
            n_checks++;
            if ({tx_dout, tx_isk, link_tx_ready} !== {e.d, e.k, e.rdy})
                $display("FAIL bringup_idle[%0d]: got %h/%b/%b required %h/%b/%b", i, tx_dout, tx_isk, link_tx_ready, e.d, e.k, e.rdy);
            else n_pass++;
        end
        linkup = 1'b1;
        link_cnt = 0;
        for (int k = 0; k <= AB + 3; k++) begin
            oob_tx_dout = 32'h0B0B_1000 + 32'(k);
            oob_tx_isk = 1'b0;
            if (k == 0) sb_tx.push_back('{d: oob_tx_dout, k: 1'b0, rdy: 1'b0});
            else        sb_tx.push_back(model_tx(k));
            link_tick();
            e = sb_tx.pop_front();
            n_checks++;
            if ({tx_dout, tx_isk, link_tx_ready, phy_ready} !== {e.d, e.k, e.rdy, e.rdy})
                $display("FAIL bringup_link[%0d]: got %h/%b/%b/%b required %h/%b/%b/%b", k, tx_dout, tx_isk, link_tx_ready, phy_ready, e.d, e.k, e.rdy, e.rdy);
            else n_pass++;
        end
    endtask

    task automatic test_periodic();
        tx_exp_t e;
        linkup = 1'b0;
        rx_auto = 1'b1;
        link_tick();
        link_tick();
        linkup = 1'b1;
        link_cnt = 0;
        for (int k = 0; k <= 4 * P; k++) begin
            oob_tx_dout = 32'h0C0C_0000 + 32'(k);
            oob_tx_isk = 1'b0;
            if (k == 0) sb_tx.push_back('{d: oob_tx_dout, k: 1'b0, rdy: 1'b0});
            else        sb_tx.push_back(model_tx(k));
            link_tick();
            e = sb_tx.pop_front();
            n_checks++;
            if ({tx_dout, tx_isk, link_tx_ready} !== {e.d, e.k, e.rdy})
                $display("FAIL periodic[%0d]: got %h/%b/%b required %h/%b/%b", k, tx_dout, tx_isk, link_tx_ready, e.d, e.k, e.rdy);
            else n_pass++;
        end
        n_checks++;
        if (platform_error !== 1'b0)
            $display("FAIL periodic_no_fault: got %b required 0", platform_error);
        else n_pass++;
    endtask

    task automatic test_rx_timeout();
        linkup = 1'b0;
        rx_auto = 1'b1;
        tick();
        tick();
        linkup = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        n_checks++;
        if (platform_error !== 1'b0) $display("FAIL timeout_pre: got %b required 0", platform_error);
        else n_pass++;
        rx_auto = 1'b0;
        rx_din = ALIGN;
        rx_isk = 4'b0001;
        tick();
        rx_din = 32'h0000_1111;
        rx_isk = 4'b0000;
        for (int j = 1; j <= TO; j++) begin
            tick();
            n_checks++;
            if (platform_error !== (j >= TO))
                $display("FAIL timeout_gap[%0d]: got %b required %b", j, platform_error, (j >= TO));
            else n_pass++;
        end
        // Dropping linkup clears the fault and returns to OOB pass-through.
        oob_tx_dout = 32'hFEED_0001;
        oob_tx_isk = 1'b0;
        linkup = 1'b0;
        tick();
        n_checks++;
        if ({platform_error, phy_ready, rx_valid} !== 3'b000)
            $display("FAIL timeout_clear: got %b%b%b required 000", platform_error, phy_ready, rx_valid);
        else n_pass++;
        tick();
        n_checks++;
        if (tx_dout !== 32'hFEED_0001) $display("FAIL timeout_idle_tx: got %h required feed0001", tx_dout);
        else n_pass++;
        // ALIGN coinciding with phy_error must not restart the gap count.
        linkup = 1'b1;
        rx_din = ALIGN;
        rx_isk = 4'b0001;
        tick();
        for (int j = 1; j <= TO; j++) begin
            if (j == 8) begin
                rx_din = ALIGN;
                rx_isk = 4'b0001;
                phy_error = 1'b1;
            end else begin
                rx_din = 32'h0000_2222;
                rx_isk = 4'b0000;
                phy_error = 1'b0;
            end
            tick();
            n_checks++;
            if (platform_error !== (j >= TO))
                $display("FAIL align_err_gap[%0d]: got %b required %b", j, platform_error, (j >= TO));
            else n_pass++;
        end
        phy_error = 1'b0;
    endtask

    task automatic test_err_density();
        logic want;
        linkup = 1'b0;
        rx_auto = 1'b1;
        phy_error = 1'b0;
        tick();
        linkup = 1'b1;
        // Windows: edges 0..30, 31..62, 63..94 (wrap-cycle error opens the new window).
        for (int k = 0; k < 96; k++) begin
            phy_error = (k == 5 || k == 10 || k == 30 || k == 31 || k == 40 || k == 50 ||
                         k == 63 || k == 70 || k == 80 || k == 90);
            tick();
            want = (k >= 90);
            n_checks++;
            if (platform_error !== want)
                $display("FAIL err_density[%0d]: got %b required %b", k, platform_error, want);
            else n_pass++;
        end
        phy_error = 1'b0;
    endtask

    task automatic test_rx_path();
        rx_exp_t e;
        logic [31:0] last_d;
        logic [3:0]  last_k;
        logic        is_align;
        rx_auto = 1'b0;
        rx_din = 32'h0;
        rx_isk = 4'b0000;
        linkup = 1'b0;
        tick();
        n_checks++;
        if (rx_valid !== 1'b0) $display("FAIL rx_valid_unlinked: got %b required 0", rx_valid);
        else n_pass++;
        last_d = 32'h0;
        last_k = 4'b0000;
        linkup = 1'b1;
        for (int i = 0; i < 12; i++) begin
            is_align = (i % 2 == 0);
            rx_din = is_align ? ALIGN : 32'h1234_5678;
            rx_isk = is_align ? 4'b0001 : 4'b0000;
`ifdef SATA_PHY_RX_ALIGN_FILTER_EN
            if (is_align) begin
                sb_rx.push_back('{d: last_d, k: last_k, v: 1'b0});
            end else begin
                sb_rx.push_back('{d: rx_din, k: rx_isk, v: 1'b1});
                last_d = rx_din;
                last_k = rx_isk;
            end
`else
            sb_rx.push_back('{d: rx_din, k: rx_isk, v: 1'b1});
`endif
            tick();
            e = sb_rx.pop_front();
            n_checks++;
            if ({rx_dout, rx_isk_out, rx_valid} !== {e.d, e.k, e.v})
                $display("FAIL rx_path[%0d]: got %h/%h/%b required %h/%h/%b", i, rx_dout, rx_isk_out, rx_valid, e.d, e.k, e.v);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        tx_exp_t e;
        rx_auto = 1'b1;
        linkup = 1'b0;
        link_tick();
        linkup = 1'b1;
        link_cnt = 0;
        for (int k = 0; k <= AB + 3; k++) link_tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({tx_dout, tx_isk, rx_dout, rx_isk_out, rx_valid} !== 70'd0)
            $display("FAIL async_reset_data: got %h/%b/%h/%h/%b required all 0", tx_dout, tx_isk, rx_dout, rx_isk_out, rx_valid);
        else n_pass++;
        n_checks++;
        if ({link_tx_ready, phy_ready, platform_error} !== 3'b000)
            $display("FAIL async_reset_flags: got %b%b%b required 000", link_tx_ready, phy_ready, platform_error);
        else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        link_cnt = 0;
        for (int k = 0; k <= AB + 3; k++) begin
            oob_tx_dout = 32'h0D0D_0000 + 32'(k);
            oob_tx_isk = 1'b0;
            if (k == 0) sb_tx.push_back('{d: oob_tx_dout, k: 1'b0, rdy: 1'b0});
            else        sb_tx.push_back(model_tx(k));
            link_tick();
            e = sb_tx.pop_front();
            n_checks++;
            if ({tx_dout, tx_isk, link_tx_ready} !== {e.d, e.k, e.rdy})
                $display("FAIL restart[%0d]: got %h/%b/%b required %h/%b/%b", k, tx_dout, tx_isk, link_tx_ready, e.d, e.k, e.rdy);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_periodic();
        test_rx_timeout();
        test_err_density();
        test_rx_path();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
